// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Optional checksum stage is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int MEM_WORDS_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream handshake plus instruction-memory write port.
// The loader sits on the slave side.
interface imem_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  we,
    input  waddr,
    input  wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output we,
    output waddr,
    output wdata
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Collects four bytes little-endian into one 32-bit word.
// word_ready flags the cycle the fourth byte is taken.
module imem_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] cnt;

  assign word_ready = en && (cnt == 2'd3);

  // Shifting in from the top leaves byte 0 in [7:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {din, word[31:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial instruction-memory loader FSM; holds the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN for the trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         error,
  output logic [6:0]   word_count
);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  nlen_q;
  logic [6:0]  wc_q;
  logic        take;
  logic        launch;
  logic        bad_len;
  logic        last_word;
  logic        word_ready;
  logic [31:0] word;

  assign take    = bus.byte_valid && bus.byte_ready;
  assign launch  = start &&
                   (state_q inside {IDLE, DONE, ERR});
  assign bad_len = (bus.byte_data == 8'd0) ||
                   (32'(bus.byte_data) >
                    32'(MEM_WORDS));
  assign last_word =
    (({1'b0, wc_q}) + 8'd1) == nlen_q;

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (launch),
    .en         (take && (state_q == DATA)),
    .din        (bus.byte_data),
    .word       (word),
    .word_ready (word_ready)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xacc_q;

  always_ff @(posedge clk) begin
    if (reset || launch) begin
      xacc_q <= '0;
    end else if (take && (state_q == DATA)) begin
      xacc_q <= xacc_q ^ bus.byte_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (take) state_d = bad_len ? ERR : DATA;
      end
      DATA: begin
        if (word_ready) state_d = WRITE;
      end
      WRITE: begin
        if (!last_word) state_d = DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else state_d = CHK;
`else
        else state_d = DONE;
`endif
      end
      CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (take) begin
          state_d = (bus.byte_data == xacc_q) ?
                    DONE : ERR;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nlen_q  <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (1'b1)
        launch: wc_q <= '0;
        (state_q == LEN) && take:
          nlen_q <= bus.byte_data;
        state_q == WRITE: wc_q <= wc_q + 7'd1;
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = state_q inside {LEN, DATA, CHK};
  assign bus.we         = state_q == WRITE;
  assign bus.waddr      = bus.we ?
                          {23'd0, wc_q, 2'b00} : 32'd0;
  assign bus.wdata      = word;
  assign cpu_reset      = !(state_q inside {IDLE, DONE});
  assign done           = state_q == DONE;
  assign error          = state_q == ERR;
  assign word_count     = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random sessions vs a byte-level model.
// Follows IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

  localparam int MW = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_reset;
  logic       done;
  logic       error;
  logic [6:0] word_count;

  imem_loader_if bus ();

  imem_loader #(.MEM_WORDS(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.slave),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t expq[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected word.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_t e;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected",
                 bus.waddr, bus.wdata);
      end else begin
        e = expq.pop_front();
        check("waddr", bus.waddr, e.a);
        check("wdata", bus.wdata, e.d);
        check("waddr_in_range",
              32'(bus.waddr <= 32'((MW - 1) * 4)), 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input bit gap,
                           input bit st);
    int t = 0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    start          = st;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start          = 1'b0;
  endtask

  task automatic session(input int n,
                         input logic [7:0] data[$],
                         input bit badchk,
                         input bit gaps,
                         input bit st);
    bit   bad;
    bit   ok;
    int   t = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
`endif
    bad = (n == 0) || (n > MW);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len_ready", 32'(bus.byte_ready), 32'd1);
    check("len_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'(n), gaps, 1'b0);
    if (!bad) begin
      for (int w = 0; w < n; w++) begin
        wr_t e;
        e.a = 32'(w * 4);
        e.d = 32'(data[4*w])
            | (32'(data[4*w+1]) << 8)
            | (32'(data[4*w+2]) << 16)
            | (32'(data[4*w+3]) << 24);
        expq.push_back(e);
      end
      for (int i = 0; i < 4 * n; i++) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = x ^ data[i];
`endif
        send_byte(data[i], gaps, st && (i != 4 * n - 1));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(badchk ? (x ^ 8'h33) : x, gaps, 1'b0);
      ok = !badchk;
`else
      @(negedge clk);
      check("done_after_write", 32'(done), 32'd1);
      ok = 1'b1;
`endif
    end else begin
      ok = 1'b0;
    end
    while (!done && !error && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done", 32'(done), 32'(ok));
    check("error", 32'(error), 32'(!ok));
    check("cpu_reset", 32'(cpu_reset), 32'(!ok));
    check("word_count", 32'(word_count), bad ? 32'd0 : 32'(n));
    check("ready_idle", 32'(bus.byte_ready), 32'd0);
    check("writes_left", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.we), 32'd0);
    check({tag, "_waddr"}, bus.waddr, 32'd0);
    check({tag, "_wdata"}, bus.wdata, 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d[$];
    logic [7:0] r[$];
    logic [7:0] none[$];
    int n;
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    d = '{8'h00, 8'h10, 8'hA0, 8'hE3,
          8'h01, 8'h20, 8'h80, 8'hE2};
    session(2, d, 1'b0, 1'b0, 1'b0);
    session(2, d, 1'b1, 1'b0, 1'b0);
    session(0, none, 1'b0, 1'b0, 1'b0);
    session(65, none, 1'b0, 1'b0, 1'b0);
    session(2, d, 1'b0, 1'b1, 1'b0);

    // Reset after six data bytes: only the first word may land.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd2, 1'b0, 1'b0);
    expq.push_back('{32'h0, 32'hE3A01000});
    for (int i = 0; i < 6; i++) send_byte(d[i], 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("mid_rst_word_count", 32'(word_count), 32'd0);
    check("mid_rst_done", 32'(done | error), 32'd0);
    check("mid_rst_writes_left", 32'(expq.size()), 32'd0);
    expq.delete();

    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    session(1, d, 1'b0, 1'b0, 1'b0);

    for (int s = 0; s < 12; s++) begin
      r.delete();
      case ($urandom_range(0, 5))
        0: n = 0;
        1: n = $urandom_range(MW + 1, 255);
        default: n = $urandom_range(1, 6);
      endcase
      if (n <= MW) begin
        for (int i = 0; i < 4 * n; i++) r.push_back(8'($urandom));
      end
      session(n, r, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    r.delete();
    for (int i = 0; i < 4 * MW; i++) r.push_back(8'($urandom));
    session(MW, r, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
